flash_word_reader: RTL and testbench
====================================

// Module: flash_word_reader
// PURPOSE
//  Upstream stage of the ROM loader: services 16-bit word reads from the DE2-115 8 MB parallel NOR flash.
//  The flash has an 8-bit data bus; each word is two byte reads.
//  Consumer interface is a toggle req/ack handshake: a request is pending while synced req != ack.
//  Consumer double-syncs ofl_ack and reads ofl_data once ack matches its req.
// PARAMETERS
//  ACCESS_CYCLES  5     iclk cycles from address/OE valid to byte sample (>= tACC 90ns at 50MHz, plus margin)
//  RESET_CYCLES   25    iclk cycles FL_RST_N is held low after reset release (>= 500ns at 50MHz)
//  RECOVER_CYCLES 3     iclk cycles after FL_RST_N rises before the first access
// PORTS
//  iclk          in   1   system clock
//  ireset_n      in   1   asynchronous, active-low reset
//  ifl_addr      in   23  word-aligned byte address; bit 0 ignored
//  ifl_req       in   1   request toggle from the consumer
//  ofl_ack       out  1   ack toggle; equals ifl_req when ofl_data holds the requested word
//  ofl_data      out  16  {byte[A], byte[A+1]}: even byte in [15:8], big-endian as the 68k sees it
//  obusy         out  1   high during flash reset sequence or an access
//  ofl_pin_addr  out  23  FL_ADDR
//  ifl_pin_dq    in   8   FL_DQ; top level ties the pad to high-Z, read-only use
//  ofl_pin_ce_n  out  1   FL_CE_N
//  ofl_pin_oe_n  out  1   FL_OE_N
//  ofl_pin_we_n  out  1   FL_WE_N, constant 1
//  ofl_pin_rst_n out  1   FL_RST_N
//  ofl_pin_wp_n  out  1   FL_WP_N, constant 0 (write-protect)
// BEHAVIOUR
//  Reset values: ofl_ack=0, ofl_data=0, obusy=1, pin_addr=0, ce_n=1, oe_n=1, rst_n=0, req sync flops=0, state=FLRST.
//  ifl_req passes through a 2-flop synchronizer giving req_s.
//  Pending request = (req_s != ofl_ack).
//  FSM:
//   FLRST:   rst_n=0; count RESET_CYCLES -> FLREC.
//   FLREC:   rst_n=1; count RECOVER_CYCLES -> IDLE.
//   IDLE:    obusy=0, ce_n=oe_n=1. If pending:
//            latch a={ifl_addr[22:1],1'b0}; pin_addr=a; ce_n=oe_n=0; obusy=1 -> RD_HI.
//   RD_HI:   wait ACCESS_CYCLES; on the final cycle capture dq into hi.
//            pin_addr=a|1 -> RD_LO (CE/OE stay low).
//   RD_LO:   wait ACCESS_CYCLES; on the final cycle ofl_data<={hi,dq}; ce_n=oe_n=1 -> DONE.
//   DONE:    ofl_ack<=~ofl_ack -> IDLE.
//  ofl_data is updated 1 cycle before ofl_ack toggles and holds until the next DONE-preceding capture.
//  Latency from req_s change to ack toggle = 2*ACCESS_CYCLES+2 cycles.
//  Wait counter is $clog2(max param + 1) bits wide, reloaded on every state entry.
//  Boundaries:
//   - Request toggled during FLRST/FLREC: stays pending, served on the first IDLE.
//   - ifl_addr changing mid-access: ignored; the latched address is used.
//   - Address 0x7FFFFE: reads bytes 0x7FFFFE and 0x7FFFFF; no wrap past 0x7FFFFF.
//   - Two req toggles before service: net no request (protocol violation, consumer must not do this).
//   - Reset asserted mid-access: all outputs return to reset values immediately.
//     FLRST sequence re-runs. The consumer shares the reset and restarts its own FSM.
//  FL_WE_N is never asserted; no command cycles are issued.
// STRUCTURE
//  Shared package/include de2115_flash_pkg: state encodings, default timing constants, FL_ADDR_W=23.
//  One natural sub-module: toggle_sync (2-flop synchronizer), reused by the consumer-side ack sync.
//  Everything else stays flat in this module.
// TESTING
//  Bench has a flash model: 8 MB byte array, dq valid 90ns after addr/oe change, else X.
//  1 Reset release: rst_n low exactly 25 cycles, then high; obusy falls 3 cycles later; ce_n/oe_n stay 1.
//  2 Model bytes [0x000100]=0xAB, [0x000101]=0xCD; addr=0x000100, toggle req
//    -> ack toggles after 12 cycles (+2 sync), data=0xABCD.
//  3 addr=0x000101 (odd) -> same pin addresses 0x100/0x101 and data 0xABCD as scenario 2.
//  4 addr=0x7FFFFE with bytes 0x12,0x34 -> data 0x1234; pin_addr never exceeds 0x7FFFFF.
//  5 Toggle req at cycle 5 of FLRST -> served right after FLREC with correct data and one ack toggle.
//  6 Assert ireset_n low during RD_LO -> ack=0, ce_n=oe_n=1, rst_n=0 the same cycle; the full sequence re-runs.
//    Back-to-back 1000 random reads via a rom_loader-style consumer all match the model.

Source files
------------

// File: rtl/flash_word_reader_pkg.sv
// Shared definitions for the DE2-115 parallel NOR flash word reader:
// address width, default timing constants and the reader state encoding.
package flash_word_reader_pkg;

    localparam int FL_ADDR_W          = 23;
    localparam int FL_WORD_W          = 16;
    localparam int FL_BYTE_W          = 8;
    localparam int DEF_ACCESS_CYCLES  = 5;
    localparam int DEF_RESET_CYCLES   = 25;
    localparam int DEF_RECOVER_CYCLES = 3;

    typedef enum logic [2:0] {
        ST_FLRST,
        ST_FLREC,
        ST_IDLE,
        ST_RD_HI,
        ST_RD_LO,
        ST_DONE
    } fl_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/flash_word_reader_if.sv
// Toggle req/ack word-read handshake between the ROM loader and the flash reader.
interface flash_word_reader_if;
    import flash_word_reader_pkg::*;

    logic [FL_ADDR_W-1:0] ifl_addr;
    logic                 ifl_req;
    logic                 ofl_ack;
    logic [FL_WORD_W-1:0] ofl_data;

    modport master (
        output ifl_addr,
        output ifl_req,
        input  ofl_ack,
        input  ofl_data
    );

    modport slave (
        input  ifl_addr,
        input  ifl_req,
        output ofl_ack,
        output ofl_data
    );
endinterface

// File: rtl/flash_word_reader_toggle_sync.sv
// Two-flop synchronizer for a single toggle signal crossing into clk;
// used for the request toggle here and for the ack toggle on the consumer side.
module toggle_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;
endmodule

// File: rtl/flash_word_reader.sv
// Reads 16-bit big-endian words from the 8-bit NOR flash as two timed byte reads,
// after running the flash reset/recovery sequence.
module flash_word_reader
    import flash_word_reader_pkg::*;
#(
    parameter int ACCESS_CYCLES  = DEF_ACCESS_CYCLES,
    parameter int RESET_CYCLES   = DEF_RESET_CYCLES,
    parameter int RECOVER_CYCLES = DEF_RECOVER_CYCLES
) (
    input  logic                 iclk,
    input  logic                 ireset_n,
    flash_word_reader_if.slave   fl,
    output logic                 obusy,
    output logic [FL_ADDR_W-1:0] ofl_pin_addr,
    input  logic [FL_BYTE_W-1:0] ifl_pin_dq,
    output logic                 ofl_pin_ce_n,
    output logic                 ofl_pin_oe_n,
    output logic                 ofl_pin_we_n,
    output logic                 ofl_pin_rst_n,
    output logic                 ofl_pin_wp_n
);
    localparam int CNT_W = $clog2(max3(ACCESS_CYCLES, RESET_CYCLES, RECOVER_CYCLES) + 1);
    localparam logic [CNT_W-1:0] ACC_LOAD = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] REC_LOAD = CNT_W'(RECOVER_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    fl_state_t              state_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [FL_ADDR_W-2:0]   addr_reg;
    logic [FL_BYTE_W-1:0]   hi_reg;
    logic                   ack_reg;
    logic [FL_WORD_W-1:0]   data_reg;
    logic                   busy_reg;
    logic [FL_ADDR_W-1:0]   pin_addr_reg;
    logic                   ce_n_reg;
    logic                   oe_n_reg;
    logic                   pin_rst_n_reg;
    logic                   req_s;
    logic                   pending;
    logic                   unused_addr_lsb;

    toggle_sync u_req_sync (
        .clk   (iclk),
        .rst_n (ireset_n),
        .d     (fl.ifl_req),
        .q     (req_s)
    );

    assign pending         = (req_s != ack_reg);
    assign unused_addr_lsb = fl.ifl_addr[0];

    // Counter is reloaded on every state change and each timed state ends when it hits zero.
    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            state_reg     <= ST_FLRST;
            cnt_reg       <= RST_LOAD;
            addr_reg      <= '0;
            hi_reg        <= '0;
            ack_reg       <= 1'b0;
            data_reg      <= '0;
            busy_reg      <= 1'b1;
            pin_addr_reg  <= '0;
            ce_n_reg      <= 1'b1;
            oe_n_reg      <= 1'b1;
            pin_rst_n_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_FLRST: begin
                    if (cnt_reg == '0) begin
                        state_reg     <= ST_FLREC;
                        cnt_reg       <= REC_LOAD;
                        pin_rst_n_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_ONE;
                    end
                end
                ST_FLREC: begin
                    if (cnt_reg == '0) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_ONE;
                    end
                end
                ST_IDLE: begin
                    if (pending) begin
                        addr_reg     <= fl.ifl_addr[FL_ADDR_W-1:1];
                        pin_addr_reg <= {fl.ifl_addr[FL_ADDR_W-1:1], 1'b0};
                        ce_n_reg     <= 1'b0;
                        oe_n_reg     <= 1'b0;
                        busy_reg     <= 1'b1;
                        cnt_reg      <= ACC_LOAD;
                        state_reg    <= ST_RD_HI;
                    end
                end
                ST_RD_HI: begin
                    if (cnt_reg == '0) begin
                        hi_reg       <= ifl_pin_dq;
                        pin_addr_reg <= {addr_reg, 1'b1};
                        cnt_reg      <= ACC_LOAD;
                        state_reg    <= ST_RD_LO;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_ONE;
                    end
                end
                ST_RD_LO: begin
                    if (cnt_reg == '0) begin
                        data_reg  <= {hi_reg, ifl_pin_dq};
                        ce_n_reg  <= 1'b1;
                        oe_n_reg  <= 1'b1;
                        state_reg <= ST_DONE;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_ONE;
                    end
                end
                ST_DONE: begin
                    ack_reg   <= ~ack_reg;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_FLRST;
                    cnt_reg   <= RST_LOAD;
                end
            endcase
        end
    end

    assign fl.ofl_ack    = ack_reg;
    assign fl.ofl_data   = data_reg;
    assign obusy         = busy_reg;
    assign ofl_pin_addr  = pin_addr_reg;
    assign ofl_pin_ce_n  = ce_n_reg;
    assign ofl_pin_oe_n  = oe_n_reg;
    assign ofl_pin_rst_n = pin_rst_n_reg;
    assign ofl_pin_we_n  = 1'b1;
    assign ofl_pin_wp_n  = 1'b0;
endmodule

// File: tb/tb_flash_word_reader.sv
// Bench for flash_word_reader: NOR flash model with 90-unit access time, a
// toggle-handshake consumer, and a word reference computed from a byte map.
module tb_flash_word_reader;
    import flash_word_reader_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy;
    logic [22:0] pin_addr;
    logic [7:0]  dq = 8'h00;
    logic        ce_n, oe_n, we_n, pin_rst_n, wp_n;
    logic        ack_s;

    int n_checks = 0;
    int n_errors = 0;

    always #10 clk = ~clk;

    flash_word_reader_if fl();

    flash_word_reader dut (
        .iclk          (clk),
        .ireset_n      (rst_n),
        .fl            (fl),
        .obusy         (busy),
        .ofl_pin_addr  (pin_addr),
        .ifl_pin_dq    (dq),
        .ofl_pin_ce_n  (ce_n),
        .ofl_pin_oe_n  (oe_n),
        .ofl_pin_we_n  (we_n),
        .ofl_pin_rst_n (pin_rst_n),
        .ofl_pin_wp_n  (wp_n)
    );

    toggle_sync u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (fl.ofl_ack),
        .q     (ack_s)
    );

    // Flash contents: explicit bytes override a fixed address hash.
    logic [7:0] mem [int];

    function automatic logic [7:0] byte_at(input int a);
        if (mem.exists(a)) return mem[a];
        return 8'((a * 37) ^ (a >> 8) ^ (a >> 15));
    endfunction

    function automatic logic [15:0] exp_word(input logic [22:0] a);
        int base;
        base = int'(a) & 32'h7FFFFE;
        return {byte_at(base), byte_at(base + 1)};
    endfunction

    // DQ is valid only 90 units after the last address/CE/OE change, garbage otherwise.
    time change_t = 0;
    always @(pin_addr or ce_n or oe_n) change_t = $time;
    always begin
        #1;
        if (!ce_n && !oe_n && ($time - change_t) >= 90) dq = byte_at(int'(pin_addr));
        else dq = 8'($urandom);
    end

    logic [22:0] seen_q[$];
    always @(posedge clk) begin
        if (!ce_n && !oe_n) begin
            if (seen_q.size() == 0 || seen_q[$] != pin_addr) seen_q.push_back(pin_addr);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset_release(input string tag);
        int  n;
        bit  bus_active;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        bus_active = 0;
        while (pin_rst_n == 1'b0 && n < 100) begin
            tick();
            n++;
            if (!ce_n || !oe_n) bus_active = 1;
        end
        check_eq({tag, "_flrst_len"}, n, 25);
        n = 0;
        while (busy == 1'b1 && n < 100) begin
            tick();
            n++;
            if (!ce_n || !oe_n) bus_active = 1;
        end
        check_eq({tag, "_flrec_len"}, n, 3);
        check_eq({tag, "_bus_quiet"}, 32'(bus_active), 0);
        $display("txn %s reset sequence done", tag);
    endtask

    task automatic do_read(input logic [22:0] a, input bit jitter, input string tag);
        logic [15:0] exp;
        int          n;
        bit          addr_ok;
        exp = exp_word(a);
        seen_q.delete();
        @(negedge clk);
        fl.ifl_addr = a;
        fl.ifl_req  = ~fl.ifl_req;
        n = 0;
        while (fl.ofl_ack != fl.ifl_req && n < 100) begin
            tick();
            n++;
            if (jitter && n >= 3) fl.ifl_addr = 23'($urandom);
        end
        check_eq({tag, "_latency"}, n, 14);
        check_eq({tag, "_data_at_ack"}, fl.ofl_data, exp);
        n = 0;
        while (ack_s != fl.ifl_req && n < 10) begin
            tick();
            n++;
        end
        check_eq({tag, "_ack_sync"}, n, 2);
        check_eq({tag, "_data"}, fl.ofl_data, exp);
        addr_ok = (seen_q.size() == 2) && (seen_q[0] == {a[22:1], 1'b0}) && (seen_q[1] == {a[22:1], 1'b1});
        check_eq({tag, "_pin_addrs"}, 32'(addr_ok), 1);
        $display("txn %s addr=%06h data=%04h exp=%04h", tag, a, fl.ofl_data, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          toggles;
        logic        ack_prev;
        logic [22:0] ra;

        fl.ifl_addr = '0;
        fl.ifl_req  = 1'b0;
        mem[32'h000100] = 8'hAB;
        mem[32'h000101] = 8'hCD;
        mem[32'h7FFFFE] = 8'h12;
        mem[32'h7FFFFF] = 8'h34;

        repeat (3) tick();
        check_eq("rst_ack", fl.ofl_ack, 0);
        check_eq("rst_data", fl.ofl_data, 0);
        check_eq("rst_busy", busy, 1);
        check_eq("rst_pin_addr", pin_addr, 0);
        check_eq("rst_ce_oe", {ce_n, oe_n}, 2'b11);
        check_eq("rst_pin_rst", pin_rst_n, 0);
        check_eq("rst_we_wp", {we_n, wp_n}, 2'b10);

        do_reset_release("s1");
        do_read(23'h000100, 0, "s2");
        do_read(23'h000101, 0, "s3");
        do_read(23'h7FFFFE, 0, "s4");

        // Request raised during FLRST must be served right after recovery.
        @(negedge clk);
        rst_n = 1'b0;
        fl.ifl_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        fl.ifl_addr = 23'h000100;
        fl.ifl_req  = 1'b1;
        n = 5;
        while (fl.ofl_ack != 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check_eq("s5_ack_cycle", n, 40);
        check_eq("s5_data", fl.ofl_data, 16'hABCD);
        toggles = 1;
        ack_prev = fl.ofl_ack;
        repeat (20) begin
            tick();
            if (fl.ofl_ack != ack_prev) toggles++;
            ack_prev = fl.ofl_ack;
        end
        check_eq("s5_ack_toggles", toggles, 1);
        check_eq("s5_ack_sync", ack_s, 1);
        $display("txn s5 ack_cycle=%0d data=%04h", n, fl.ofl_data);

        // Reset in the middle of the low-byte read.
        @(negedge clk);
        fl.ifl_addr = 23'h7FFFFE;
        fl.ifl_req  = ~fl.ifl_req;
        repeat (10) tick();
        check_eq("s6_busy_before", busy, 1);
        check_eq("s6_ce_before", ce_n, 0);
        check_eq("s6_addr_before", pin_addr, 23'h7FFFFF);
        #5;
        rst_n = 1'b0;
        fl.ifl_req = 1'b0;
        #1;
        check_eq("s6_ack", fl.ofl_ack, 0);
        check_eq("s6_ce_oe", {ce_n, oe_n}, 2'b11);
        check_eq("s6_pin_rst", pin_rst_n, 0);
        check_eq("s6_busy", busy, 1);
        check_eq("s6_data", fl.ofl_data, 0);
        check_eq("s6_pin_addr", pin_addr, 0);
        $display("txn s6 reset asserted mid-access");
        repeat (2) @(negedge clk);
        do_reset_release("s6");
        do_read(23'h000100, 0, "s6_after");

        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 7) == 0) ra = 23'h7FFFFF - 23'($urandom_range(0, 3));
            else ra = 23'($urandom);
            do_read(ra, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
